// File: rtl/if_stage_if.sv
// Fetch-stage bundle: pipeline control into IF, instruction memory port, and the IF/ID register outputs.
interface if_stage_if;
    logic        stall;
    logic [2:0]  PCSrc;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        Supervised;

    modport master (
        output stall, PCSrc, jump_index, jr_target, branch_taken, branch_target, imem_data,
        input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, Supervised
    );

    modport slave (
        input  stall, PCSrc, jump_index, jr_target, branch_taken, branch_target, imem_data,
        output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, Supervised
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter logic [31:0] ILLOP    = 32'h80000004,
    parameter logic [31:0] XADR     = 32'h80000008
) (
    input  logic      clk,
    input  logic      reset,
    if_stage_if.slave bus
);
    localparam logic [31:0] RESET_PC_PLUS4 = {RESET_PC[31], RESET_PC[30:0] + 31'd4};

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] jump_target;
    logic [2:0]  src;
    logic        redirect;

    logic [31:0] id_instr_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_pc_plus4_q;
    logic        id_valid_q;

    // The supervisor bit is sticky across sequential fetch; only redirects can change it.
    assign pc_plus4    = {pc[31], pc[30:0] + 31'd4};
    assign jump_target = {id_pc_plus4_q[31:28], bus.jump_index, 2'b00};

    // A bubble in ID carries no decoded redirect, except an IRQ which must not be lost.
    always_comb begin
        src = bus.PCSrc;
        if (src > 3'd4) begin
            src = 3'd0;
        end
        if (!id_valid_q && (src != 3'd3)) begin
            src = 3'd0;
        end
    end

    assign redirect = bus.branch_taken || (!bus.stall && (src != 3'd0));

    always_comb begin
        pc_next = pc_plus4;
        if (bus.branch_taken) begin
            pc_next = bus.branch_target;
        end else if (bus.stall) begin
            pc_next = pc;
        end else begin
            case (src)
                3'd1:    pc_next = jump_target;
                3'd2:    pc_next = bus.jr_target;
                3'd3:    pc_next = ILLOP;
                3'd4:    pc_next = XADR;
                default: pc_next = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // On a redirect the in-flight fetch is squashed; id_pc keeps the last real instruction's PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr_q    <= 32'd0;
            id_pc_q       <= RESET_PC;
            id_pc_plus4_q <= RESET_PC_PLUS4;
            id_valid_q    <= 1'b0;
        end else if (redirect) begin
            id_instr_q <= 32'd0;
            id_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            id_instr_q    <= bus.imem_data;
            id_pc_q       <= pc;
            id_pc_plus4_q <= pc_plus4;
            id_valid_q    <= 1'b1;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.Supervised  = id_pc_q[31];
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized control against a reference model.
module tb_if_stage;
    logic clk;
    logic reset;
    logic fixed_mem;
    int   n_cmp;
    int   n_fail;

    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
    logic        m_valid;

    if_stage_if bus();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]} + 32'h13579BDF;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return fixed_mem ? 32'h20080001 : mem_fn(a);
    endfunction

    assign bus.imem_data = mem_read(bus.imem_addr);

    task automatic model_reset();
        m_pc    = 32'h80000000;
        m_instr = 32'd0;
        m_idpc  = 32'h80000000;
        m_idpc4 = 32'h80000004;
        m_valid = 1'b0;
    endtask

    // Reference: priority rules applied directly with arithmetic on the previous cycle's state.
    task automatic model_step();
        logic [31:0] p4, npc;
        int          s;
        bit          bubble;
        p4 = (m_pc & 32'h80000000) | ((m_pc + 32'd4) & 32'h7FFFFFFF);
        s  = int'(bus.PCSrc);
        if (s > 4) s = 0;
        if (m_valid == 1'b0 && s != 3) s = 0;
        bubble = bus.branch_taken || (!bus.stall && s != 0);
        if (bus.branch_taken)      npc = bus.branch_target;
        else if (bus.stall)        npc = m_pc;
        else if (s == 1)           npc = (m_idpc4 & 32'hF0000000) | (32'(bus.jump_index) << 2);
        else if (s == 2)           npc = bus.jr_target;
        else if (s == 3)           npc = 32'h80000004;
        else if (s == 4)           npc = 32'h80000008;
        else                       npc = p4;
        if (bubble) begin
            m_instr = 32'd0;
            m_valid = 1'b0;
        end else if (!bus.stall) begin
            m_instr = mem_read(m_pc);
            m_idpc  = m_pc;
            m_idpc4 = p4;
            m_valid = 1'b1;
        end
        m_pc = npc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit bt, input logic [31:0] bta, input bit st,
                         input logic [2:0] src, input logic [25:0] ji, input logic [31:0] jr);
        bus.branch_taken  = bt;
        bus.branch_target = bta;
        bus.stall         = st;
        bus.PCSrc         = src;
        bus.jump_index    = ji;
        bus.jr_target     = jr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fixed_mem = 1'b1;
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        model_reset();
        #12;
        n_cmp++; if (bus.imem_addr !== 32'h80000000) begin n_fail++; $display("FAIL reset_pc got %h want 80000000", bus.imem_addr); end
        n_cmp++; if (bus.id_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", bus.id_instr); end
        n_cmp++; if (bus.id_pc !== 32'h80000000) begin n_fail++; $display("FAIL reset_idpc got %h want 80000000", bus.id_pc); end
        n_cmp++; if (bus.id_pc_plus4 !== 32'h80000004) begin n_fail++; $display("FAIL reset_idpc4 got %h want 80000004", bus.id_pc_plus4); end
        n_cmp++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.id_valid); end
        n_cmp++; if (bus.Supervised !== 1'b1) begin n_fail++; $display("FAIL reset_sup got %b want 1", bus.Supervised); end
    endtask

    task automatic test_seq_fetch();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'h80000000) begin n_fail++; $display("FAIL seq_addr0 got %h want 80000000", bus.imem_addr); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h80000004) begin n_fail++; $display("FAIL seq_addr1 got %h want 80000004", bus.imem_addr); end
        n_cmp++; if (bus.id_instr !== 32'h20080001) begin n_fail++; $display("FAIL seq_instr got %h want 20080001", bus.id_instr); end
        n_cmp++; if (bus.id_pc !== 32'h80000000) begin n_fail++; $display("FAIL seq_idpc got %h want 80000000", bus.id_pc); end
        n_cmp++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid got %b want 1", bus.id_valid); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h80000008) begin n_fail++; $display("FAIL seq_addr2 got %h want 80000008", bus.imem_addr); end
        fixed_mem = 1'b0;
    endtask

    task automatic test_jump();
        drive(1, 32'h0040000C, 0, 3'd0, 26'd0, 32'd0);
        tick();
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        tick();
        n_cmp++; if (bus.id_pc_plus4 !== 32'h00400010) begin n_fail++; $display("FAIL jump_setup got %h want 00400010", bus.id_pc_plus4); end
        drive(0, 32'd0, 0, 3'd1, 26'h0100000, 32'd0);
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h00400000) begin n_fail++; $display("FAIL jump_pc got %h want 00400000", bus.imem_addr); end
        n_cmp++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL jump_bubble got %b want 0", bus.id_valid); end
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        tick();
        n_cmp++; if (bus.id_pc !== 32'h00400000) begin n_fail++; $display("FAIL jump_idpc got %h want 00400000", bus.id_pc); end
        n_cmp++; if (bus.Supervised !== 1'b0) begin n_fail++; $display("FAIL jump_sup got %b want 0", bus.Supervised); end
    endtask

    task automatic test_branch_stall();
        logic [31:0] hold_pc, hold_instr;
        drive(1, 32'h00400100, 1, 3'd2, 26'd0, 32'h12345678);
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h00400100) begin n_fail++; $display("FAIL brst_pc got %h want 00400100", bus.imem_addr); end
        n_cmp++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'd0) begin n_fail++; $display("FAIL brst_bubble got %b/%h want 0/0", bus.id_valid, bus.id_instr); end
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        tick();
        hold_pc = 32'h00400104;
        hold_instr = mem_fn(32'h00400100);
        drive(0, 32'd0, 1, 3'd1, 26'h3FFFFFF, 32'd0);
        tick();
        tick();
        n_cmp++; if (bus.imem_addr !== hold_pc) begin n_fail++; $display("FAIL stall_pc got %h want %h", bus.imem_addr, hold_pc); end
        n_cmp++; if (bus.id_instr !== hold_instr || bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_instr got %h/%b want %h/1", bus.id_instr, bus.id_valid, hold_instr); end
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        tick();
    endtask

    task automatic test_irq_xadr();
        drive(0, 32'd0, 0, 3'd3, 26'd0, 32'd0);
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h80000004) begin n_fail++; $display("FAIL irq_pc got %h want 80000004", bus.imem_addr); end
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        tick();
        n_cmp++; if (bus.Supervised !== 1'b1 || bus.id_pc !== 32'h80000004) begin n_fail++; $display("FAIL irq_sup got %b/%h want 1/80000004", bus.Supervised, bus.id_pc); end
        drive(0, 32'd0, 0, 3'd4, 26'd0, 32'd0);
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h80000008) begin n_fail++; $display("FAIL xadr_pc got %h want 80000008", bus.imem_addr); end
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        tick();
        n_cmp++; if (bus.Supervised !== 1'b1 || bus.id_pc !== 32'h80000008) begin n_fail++; $display("FAIL xadr_sup got %b/%h want 1/80000008", bus.Supervised, bus.id_pc); end
    endtask

    task automatic test_wrap();
        drive(1, 32'hFFFFFFFC, 0, 3'd0, 26'd0, 32'd0);
        tick();
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h80000000) begin n_fail++; $display("FAIL wrap_sup got %h want 80000000", bus.imem_addr); end
        drive(1, 32'h7FFFFFFC, 0, 3'd0, 26'd0, 32'd0);
        tick();
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h00000000) begin n_fail++; $display("FAIL wrap_user got %h want 00000000", bus.imem_addr); end
        n_cmp++; if (bus.id_pc_plus4 !== 32'h00000000) begin n_fail++; $display("FAIL wrap_idpc4 got %h want 00000000", bus.id_pc_plus4); end
    endtask

    task automatic test_reset_mid();
        drive(0, 32'd0, 1, 3'd2, 26'd0, 32'h00001000);
        tick();
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'h80000000) begin n_fail++; $display("FAIL midrst_pc got %h want 80000000", bus.imem_addr); end
        n_cmp++; if (bus.id_valid !== 1'b0 || bus.Supervised !== 1'b1) begin n_fail++; $display("FAIL midrst_valid got %b/%b want 0/1", bus.id_valid, bus.Supervised); end
        model_reset();
        @(negedge clk);
        drive(0, 32'd0, 0, 3'd0, 26'd0, 32'd0);
        reset = 1'b0;
        tick();
        n_cmp++; if (bus.id_pc !== 32'h80000000 || bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_resume got %h/%b want 80000000/1", bus.id_pc, bus.id_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 4) == 0, $urandom & 32'hFFFFFFFC, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
                  26'($urandom), $urandom & 32'hFFFFFFFC);
            tick();
            n_cmp++;
            if (bus.imem_addr !== m_pc || bus.id_instr !== m_instr || bus.id_pc !== m_idpc ||
                bus.id_pc_plus4 !== m_idpc4 || bus.id_valid !== m_valid || bus.Supervised !== m_idpc[31]) begin
                n_fail++;
                $display("FAIL rand[%0d] got pc=%h ins=%h idpc=%h idpc4=%h v=%b s=%b want pc=%h ins=%h idpc=%h idpc4=%h v=%b s=%b",
                         i, bus.imem_addr, bus.id_instr, bus.id_pc, bus.id_pc_plus4, bus.id_valid, bus.Supervised,
                         m_pc, m_instr, m_idpc, m_idpc4, m_valid, m_idpc[31]);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_seq_fetch();
        test_jump();
        test_branch_stall();
        test_irq_xadr();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
